// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, command encodings and sequencer states shared by alu_seq_ctrl.
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SRL1 = 4'b1100;
  localparam logic [3:0] ALU_SLL1 = 4'b1101;
  localparam logic [1:0] CMD_SLL = 2'b00;
  localparam logic [1:0] CMD_SRL = 2'b01;
  localparam logic [1:0] CMD_MUL = 2'b10;
  localparam logic [1:0] CMD_RSV = 2'b11;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_MUL_ADD = 3'd2;
  localparam logic [2:0] ST_MUL_SHL = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences an external single-cycle ALU to perform multi-bit shifts and shift-add multiply.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);
  logic [2:0] state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d, acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d, result_q, result_d;
  logic [4:0] count_q, count_d;
  logic srl_q, srl_d, err_q, err_d;
  logic st_shift, st_madd, st_mshl;
  assign st_shift  = state_q == ST_SHIFT;
  assign st_madd   = state_q == ST_MUL_ADD;
  assign st_mshl   = state_q == ST_MUL_SHL;
  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign out_result = out_valid ? result_q : '0;
  assign out_zero   = out_valid && result_q == '0;
  assign out_err    = out_valid && err_q;
  assign alu_op = st_shift ? (srl_q ? ALU_SRL1 : ALU_SLL1) : st_mshl ? ALU_SLL1 : ALU_ADD;
  assign alu_a  = st_shift ? work_q : st_madd ? acc_q : st_mshl ? mcand_q : '0;
  assign alu_b  = (st_madd && mplier_q[0]) ? mcand_q : '0;
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    count_d  = count_q;
    srl_d    = srl_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        srl_d    = in_cmd == CMD_SRL;
        err_d    = in_cmd == CMD_RSV;
        work_d   = in_a;
        count_d  = in_b[4:0];
        acc_d    = '0;
        mcand_d  = in_a;
        mplier_d = in_b;
        result_d = '0;
        if (in_cmd == CMD_RSV)
          state_d = ST_DONE;
        else if (in_cmd == CMD_MUL)
          state_d = (in_b == '0) ? ST_DONE : ST_MUL_ADD;
        else if (in_b[4:0] == 5'd0) begin
          state_d  = ST_DONE;
          result_d = in_a;
        end else
          state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        work_d  = alu_result;
        count_d = count_q - 5'd1;
        if (count_q == 5'd1) begin
          state_d  = ST_DONE;
          result_d = alu_result;
        end
      end
      ST_MUL_ADD: begin
        acc_d   = alu_result;
        state_d = ST_MUL_SHL;
      end
      ST_MUL_SHL: begin
        mcand_d  = alu_result;
        mplier_d = mplier_q >> 1;
        if (mplier_d == '0) begin
          state_d  = ST_DONE;
          result_d = acc_q;
        end else
          state_d = ST_MUL_ADD;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      count_q  <= '0;
      srl_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      count_q  <= count_d;
      srl_q    <= srl_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vector table plus hand sequences for back-pressure and mid-operation reset.
module tb_alu_seq_ctrl;
  import alu_pkg::*;
  localparam int W = 32;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [1:0] in_cmd = 0;
  logic [W-1:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, out_zero, out_err;
  logic [W-1:0] out_result, alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  int tests = 0, fails = 0;
  typedef struct {
    logic [1:0] cmd;
    logic [W-1:0] a, b, res;
    logic z, e;
    int lat, hold;
  } vec_t;
  vec_t v [12];
  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_err(out_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );
  always #5 clk = ~clk;
  // Reference single-cycle ALU living in the enclosing datapath
  always_comb
    alu_result = alu_op == ALU_ADD ? alu_a + alu_b :
                 alu_op == ALU_SRL1 ? alu_a >> 1 :
                 alu_op == ALU_SLL1 ? alu_a << 1 : '0;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic run(input logic [1:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int hold, input bit pend, output logic [W-1:0] res,
                     output logic z, output logic e, output int lat);
    int g = 0;
    @(negedge clk);
    in_valid = 1; in_cmd = cmd; in_a = a; in_b = b;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    @(negedge clk);
    if (pend) begin in_cmd = CMD_SLL; in_a = 1; in_b = 1; end
    else begin in_valid = 0; in_cmd = 2'($urandom); in_a = $urandom; in_b = $urandom; end
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    res = out_result; z = out_zero; e = out_err;
    check("alu_idle_in_done", {alu_op, alu_a | alu_b}, 0);
    repeat (hold) begin
      @(negedge clk);
      check("hold_stable", {out_valid, in_ready, out_zero, out_err, out_result}, {2'b10, z, e, res});
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("consumed_gap", {out_valid, in_ready}, 2'b01);
  endtask
  initial begin
    logic [W-1:0] res;
    logic z, e;
    int lat;
    v[0]  = '{CMD_SLL, 32'h1, 32'd31, 32'h80000000, 0, 0, 31, 0};
    v[1]  = '{CMD_SRL, 32'h80000000, 32'h24, 32'h08000000, 0, 0, 4, 0};
    v[2]  = '{CMD_SRL, 32'h80000000, 32'h0, 32'h80000000, 0, 0, 0, 1};
    v[3]  = '{CMD_MUL, 32'd7, 32'd6, 32'd42, 0, 0, 6, 2};
    v[4]  = '{CMD_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 0, 0, 64, 0};
    v[5]  = '{CMD_MUL, 32'd5, 32'd0, 32'd0, 1, 0, 0, 0};
    v[6]  = '{CMD_RSV, 32'h1234, 32'h5, 32'd0, 1, 1, 0, 3};
    v[7]  = '{CMD_SLL, 32'hF0000000, 32'd4, 32'd0, 1, 0, 4, 0};
    v[8]  = '{CMD_MUL, 32'd3, 32'd1, 32'd3, 0, 0, 2, 0};
    v[9]  = '{CMD_SRL, 32'hDEADBEEF, 32'd8, 32'h00DEADBE, 0, 0, 8, 0};
    v[10] = '{CMD_MUL, 32'h10000, 32'h10000, 32'd0, 1, 0, 34, 0};
    v[11] = '{CMD_SLL, 32'h0000ABCD, 32'hFFFFFFE3, 32'h00055E68, 0, 0, 3, 0};
    repeat (2) @(negedge clk);
    check("reset_outputs", {in_ready, out_valid, out_zero, out_err, out_result}, {4'b1000, 32'h0});
    check("reset_alu", {alu_op, alu_a | alu_b}, 0);
    rst = 0;
    foreach (v[i]) begin
      run(v[i].cmd, v[i].a, v[i].b, v[i].hold, 0, res, z, e, lat);
      check($sformatf("v%0d_result", i), res, v[i].res);
      check($sformatf("v%0d_zero_err", i), {z, e}, {v[i].z, v[i].e});
      check($sformatf("v%0d_latency", i), lat, v[i].lat);
    end
    // Back-pressure for 5 cycles with a second command waiting behind it
    run(CMD_MUL, 32'd7, 32'd6, 5, 1, res, z, e, lat);
    check("bp_result", res, 42);
    check("bp_latency", lat, 6);
    @(negedge clk);
    in_valid = 0;
    check("pend_accepted", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    check("pend_result", {out_result, lat[7:0]}, {32'd2, 8'd1});
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    // Reset during MUL_ADD
    in_valid = 1; in_cmd = CMD_MUL; in_a = 32'h1234; in_b = 32'h5678;
    @(negedge clk);
    in_valid = 0;
    check("mul_add_busy", {in_ready, alu_op}, {1'b0, ALU_ADD});
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_outputs", {in_ready, out_valid, out_zero, out_err, out_result}, {4'b1000, 32'h0});
    check("midrst_alu", {alu_op, alu_a | alu_b}, 0);
    run(CMD_MUL, 32'h1234, 32'h5678, 0, 0, res, z, e, lat);
    check("post_rst_result", {res, z, e}, {32'h06260060, 2'b00});
    check("post_rst_latency", lat, 30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; all data ports below are WIDTH bits.
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  single clock; all state updates on rising edge.
  rst  in  1  synchronous, active-high reset.
  in_valid  in  1  command valid.
  in_ready  out  1  block can accept a command.
  in_cmd  in  2  00=SLL, 01=SRL, 10=MUL (unsigned, low WIDTH bits), 11=reserved.
  in_a  in  WIDTH  shift source / multiplicand.
  in_b  in  WIDTH  shift amount (bits [4:0] only) / multiplier.
  out_valid  out  1  result valid.
  out_ready  in  1  consumer accepts result.
  out_result  out  WIDTH  result.
  out_zero  out  1  out_result == 0.
  out_err  out  1  reserved command received.
  alu_a  out  WIDTH  to ALU operand A.
  alu_b  out  WIDTH  to ALU operand B.
  alu_op  out  4  to ALU op code.
  alu_result  in  WIDTH  from ALU result.

Function
REQ-003 SHALL sequence the external single-cycle ALU; ALU codes used: 0000 add, 1100 shift right by 1, 1101 shift left by 1.
REQ-004 SHALL implement states IDLE, SHIFT, MUL_ADD, MUL_SHL, DONE.
REQ-005 SHALL assert in_ready only in IDLE; accept occurs on an edge with in_valid & in_ready (accept edge E0).
REQ-006 SHALL on accept latch operands: work<=in_a, count<=in_b[4:0] (shifts); acc<=0, mcand<=in_a, mplier<=in_b (MUL).
REQ-007 SHALL for SLL/SRL with count N>0 enter SHIFT; each SHIFT cycle drive alu_op=1101 (SLL) or 1100 (SRL), alu_a=work, alu_b=0, latch work<=alu_result, count<=count-1; leave to DONE on the edge where count reaches 0.
REQ-008 SHALL for shift count 0 go IDLE->DONE at E0 with result=in_a.
REQ-009 SHALL for MUL with in_b==0 go IDLE->DONE at E0 with result 0; otherwise enter MUL_ADD.
REQ-010 SHALL in MUL_ADD drive alu_op=0000, alu_a=acc, alu_b=(mplier[0] ? mcand : 0), latch acc<=alu_result, next MUL_SHL.
REQ-011 SHALL in MUL_SHL drive alu_op=1101, alu_a=mcand, alu_b=0, latch mcand<=alu_result, mplier<=mplier>>1; next DONE if shifted mplier==0, else MUL_ADD.
REQ-012 SHALL discard carries/shifted-out bits (modulo 2^WIDTH arithmetic).
REQ-013 Latency: out_valid first high in the cycle after edge E0+N (shift), E0+2k (MUL, k = index of highest set bit of in_b plus 1), E0 (count 0, multiplier 0, reserved).
REQ-014 SHALL in DONE hold out_valid=1 and out_result/out_zero/out_err stable until out_ready; on out_valid & out_ready edge return to IDLE.
REQ-015 SHALL not accept a new command in the same cycle a result is consumed (one-cycle IDLE gap).
REQ-016 SHALL for in_cmd=11 go to DONE with out_result=0, out_zero=1, out_err=1; out_err=0 for all other commands.
REQ-017 SHALL drive alu_op=0000, alu_a=0, alu_b=0 in IDLE and DONE.
REQ-018 SHALL ignore in_* changes while not in IDLE.

Reset
REQ-019 SHALL on rst (any state, including mid-operation) enter IDLE next edge; out_valid=0, out_result=0, out_zero=0, out_err=0, in_ready=1, internal registers 0; in-flight command discarded.
REQ-020 SHALL give rst priority over accept and consume in the same cycle.

Structure
REQ-021 SHALL place ALU op-code constants (ADD, SRL1, SLL1), command encodings, and the state enumeration in shared package alu_pkg.
REQ-022 SHALL contain no sub-module; the ALU instance lives in the enclosing datapath and connects via alu_* ports.

Verification
REQ-023 SLL in_a=0x00000001, in_b=31 -> out_result=0x80000000, out_valid after edge E0+31, out_zero=0.
REQ-024 SRL in_a=0x80000000, in_b=0x24 (uses 4) -> 0x08000000 after E0+4; in_b=0 -> in_a after E0.
REQ-025 MUL 7x6 -> 42 after E0+6; MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001 after E0+64; MUL x0 -> 0, out_zero=1 after E0.
REQ-026 out_ready low 5 cycles in DONE -> out_result stable, in_ready=0, second in_valid held off until one cycle after consume.
REQ-027 rst asserted during MUL_ADD of 0x1234x0x5678 -> IDLE next edge, all outputs 0, in_ready=1; next command completes correctly.
REQ-028 in_cmd=11 -> out_err=1, out_result=0, out_zero=1 after E0; ALU ports at 0 throughout.
